// File: rtl/lcd_feed_queue_if.sv
// Handshake bundle between value producers, the feed queue and the display controller.
// No latency of its own; it only groups wires.
// Producers see IN_FULL/DROP_CNT. The display side paces the queue via LCD_READY.
interface lcd_feed_queue_if #(
  parameter int DIGIT = 8
);
  logic [DIGIT*4-1:0] IN_DATA;
  logic               IN_WE;
  logic               IN_FULL;
  logic               EMPTY;
  logic [DIGIT*4-1:0] OUT_DATA;
  logic               OUT_WE;
  logic               LCD_READY;
  logic [7:0]         DROP_CNT;

  // Producer / display-controller side
  modport master (
    output IN_DATA, IN_WE, LCD_READY,
    input  IN_FULL, EMPTY, OUT_DATA, OUT_WE, DROP_CNT
  );

  // Queue side
  modport slave (
    input  IN_DATA, IN_WE, LCD_READY,
    output IN_FULL, EMPTY, OUT_DATA, OUT_WE, DROP_CNT
  );
endinterface

// File: rtl/lcd_feed_queue.sv
// Buffers hex-display values and hands them to the serial display controller one at a time.
// Latency: a push into an empty queue with LCD_READY high gives an OUT_WE pulse 2 cycles later.
// Producers are never stalled: a push into a full queue with no same-cycle pop is dropped and counted.
module lcd_feed_queue #(
  parameter int DIGIT     = 8,
  parameter int DEPTH_LOG = 3
) (
  input  logic            CLK,
  input  logic            RST,
  lcd_feed_queue_if.slave bus
);
  localparam int W     = DIGIT * 4;
  localparam int DEPTH = 1 << DEPTH_LOG;
  localparam logic [DEPTH_LOG:0] C_FULL = {1'b1, {DEPTH_LOG{1'b0}}};

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACK  = 2'd1;
  localparam logic [1:0] S_BUSY = 2'd2;

  logic [W-1:0]         r_mem [DEPTH];
  logic [DEPTH_LOG-1:0] r_wr_ptr;
  logic [DEPTH_LOG-1:0] r_rd_ptr;
  logic [DEPTH_LOG:0]   r_count;
  logic [1:0]           r_state;
  logic [W-1:0]         r_out_data;
  logic                 r_out_we;
  logic [7:0]           r_drop_cnt;

  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push;
  logic w_drop;

  // Status is decoded from the registered count so it moves one cycle after the causing edge.
  assign w_full  = (r_count == C_FULL);
  assign w_empty = (r_count == '0);

  // A pop is only taken from S_IDLE; that lets a push into a full queue ride on it.
  assign w_pop  = (r_state == S_IDLE) && !w_empty && bus.LCD_READY;
  assign w_push = bus.IN_WE && (!w_full || w_pop);
  assign w_drop = bus.IN_WE && w_full && !w_pop;

  // Entry storage; contents need no reset because count and pointers define validity.
  always_ff @(posedge CLK) begin
    if (!RST && w_push) begin
      r_mem[r_wr_ptr] <= bus.IN_DATA;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  // Saturating count of pushes lost to a full queue.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
      r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  // Issue sequencer: one strobe per READY low-then-high cycle of the controller.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_out_we   <= 1'b0;
      r_out_data <= '0;
    end else begin
      r_out_we <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_out_data <= r_mem[r_rd_ptr];
            r_out_we   <= 1'b1;
            r_state    <= S_ACK;
          end
        end
        // The controller lowers READY one cycle after it samples WE.
        S_ACK: begin
          if (!bus.LCD_READY) begin
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (bus.LCD_READY) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.IN_FULL  = w_full;
  assign bus.EMPTY    = w_empty;
  assign bus.OUT_DATA = r_out_data;
  assign bus.OUT_WE   = r_out_we;
  assign bus.DROP_CNT = r_drop_cnt;
endmodule

// File: tb/tb_lcd_feed_queue.sv
// Bench for lcd_feed_queue: directed scenarios plus a random phase, scored every cycle
// against a queue-level model of the feeder and a simple display-controller model.
module tb_lcd_feed_queue;
  localparam int DIGIT     = 8;
  localparam int DEPTH_LOG = 3;
  localparam int W         = DIGIT * 4;
  localparam int DEPTH     = 1 << DEPTH_LOG;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  lcd_feed_queue_if #(.DIGIT(DIGIT)) bus ();

  lcd_feed_queue #(.DIGIT(DIGIT), .DEPTH_LOG(DEPTH_LOG)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  initial begin
    forever #5 CLK = ~CLK;
  end

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Display controller model: drops READY the cycle after it sees WE, holds it low
  // for a random number of cycles (the serial transfer), and aborts on reset.
  bit ctl_auto     = 1'b1;
  bit ctl_force    = 1'b1;
  int ctl_hold_min = 3;
  int ctl_hold_max = 3;
  int ctl_cnt      = 0;
  bit we_seen      = 1'b0;

  initial begin
    bus.LCD_READY = 1'b1;
    forever begin
      @(negedge CLK);
      we_seen = (bus.OUT_WE === 1'b1);
      @(posedge CLK);
      #2;
      if (RST) ctl_cnt = 0;
      else if (we_seen) ctl_cnt = int'($urandom_range(ctl_hold_max, ctl_hold_min));
      else if (ctl_cnt > 0) ctl_cnt--;
      bus.LCD_READY = ctl_auto ? (ctl_cnt == 0) : ctl_force;
    end
  end

  // Reference model: a bounded FIFO of values plus the rule that a new issue needs
  // READY to have been seen low and then high again since the previous issue.
  logic [W-1:0] ref_q[$];
  int           ref_drops = 0;
  bit           wait_low  = 1'b0;
  bit           wait_high = 1'b0;
  logic         exp_we    = 1'b0;
  logic [W-1:0] exp_data  = '0;
  logic [W-1:0] out_log[$];
  int           pulse_cyc[$];
  int           pulse_cnt = 0;
  int           cyc       = 0;
  bit           p_valid   = 1'b0;
  logic         p_rst, p_we, p_rdy;
  logic [W-1:0] p_dat;

  initial begin
    forever begin
      @(negedge CLK);
      cyc++;
      if (p_valid) begin
        if (p_rst) begin
          ref_q.delete();
          ref_drops = 0;
          wait_low  = 1'b0;
          wait_high = 1'b0;
          exp_we    = 1'b0;
          exp_data  = '0;
        end else begin
          bit pop;
          pop = !wait_low && !wait_high && (p_rdy === 1'b1) && (ref_q.size() > 0);
          if (pop) begin
            exp_data = ref_q.pop_front();
            wait_low = 1'b1;
          end else if (wait_low && (p_rdy === 1'b0)) begin
            wait_low  = 1'b0;
            wait_high = 1'b1;
          end else if (wait_high && (p_rdy === 1'b1)) begin
            wait_high = 1'b0;
          end
          exp_we = pop;
          if (p_we === 1'b1) begin
            if (ref_q.size() < DEPTH) ref_q.push_back(p_dat);
            else if (ref_drops < 255) ref_drops++;
          end
        end
        check("cyc_out_we",   W'(bus.OUT_WE),   W'(exp_we));
        check("cyc_out_data", bus.OUT_DATA,     exp_data);
        check("cyc_in_full",  W'(bus.IN_FULL),  W'(ref_q.size() == DEPTH));
        check("cyc_empty",    W'(bus.EMPTY),    W'(ref_q.size() == 0));
        check("cyc_drop_cnt", W'(bus.DROP_CNT), W'(ref_drops));
        if (bus.OUT_WE === 1'b1) begin
          out_log.push_back(bus.OUT_DATA);
          pulse_cyc.push_back(cyc);
          pulse_cnt++;
        end
      end
      p_rst   = RST;
      p_we    = bus.IN_WE;
      p_rdy   = bus.LCD_READY;
      p_dat   = bus.IN_DATA;
      p_valid = 1'b1;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [W-1:0] d);
    bus.IN_WE   = 1'b1;
    bus.IN_DATA = d;
    tick();
    bus.IN_WE   = 1'b0;
  endtask

  task automatic wait_pulses(input int target, input int budget, input string tag);
    int n = 0;
    while ((pulse_cnt < target) && (n < budget)) begin
      tick();
      n++;
    end
    check(tag, W'(pulse_cnt), W'(target));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  logic [W-1:0] vals[DEPTH + 2];
  int base;
  int gap;

  initial begin
    bus.IN_WE   = 1'b0;
    bus.IN_DATA = '0;
    RST         = 1'b1;
    repeat (3) tick();
    RST = 1'b0;
    check("rst_empty",    W'(bus.EMPTY),    W'(1));
    check("rst_full",     W'(bus.IN_FULL),  W'(0));
    check("rst_drop",     W'(bus.DROP_CNT), W'(0));
    check("rst_out_we",   W'(bus.OUT_WE),   W'(0));
    check("rst_out_data", bus.OUT_DATA,     '0);
    repeat (2) tick();

    // Single value, latency n+2
    ctl_hold_min = 5;
    ctl_hold_max = 5;
    bus.IN_WE   = 1'b1;
    bus.IN_DATA = 32'h1234ABCD;
    tick();
    bus.IN_WE = 1'b0;
    check("lat_n1_we",   W'(bus.OUT_WE), W'(0));
    tick();
    check("lat_n2_we",   W'(bus.OUT_WE), W'(1));
    check("lat_n2_data", bus.OUT_DATA,   32'h1234ABCD);
    tick();
    check("lat_n3_we",   W'(bus.OUT_WE), W'(0));
    check("lat_hold",    bus.OUT_DATA,   32'h1234ABCD);
    repeat (20) tick();

    // Ordering with a slow controller
    ctl_hold_min = 100;
    ctl_hold_max = 100;
    base = pulse_cnt;
    push(32'h1);
    push(32'h2);
    push(32'h3);
    wait_pulses(base + 3, 600, "order_pulses");
    for (int i = 0; i < 3; i++) check("order_val", out_log[base + i], W'(i + 1));
    gap = pulse_cyc[base + 1] - pulse_cyc[base];
    check("order_gap", W'(gap >= 100), W'(1));
    repeat (120) tick();

    // Overflow: READY held low, 10 pushes into 8 slots
    ctl_hold_min = 4;
    ctl_hold_max = 4;
    ctl_auto  = 1'b0;
    ctl_force = 1'b0;
    tick();
    base = pulse_cnt;
    for (int i = 0; i < 10; i++) begin
      vals[i] = $urandom;
      push(vals[i]);
      if (i == 6) check("ovf_full_7", W'(bus.IN_FULL), W'(0));
      if (i == 7) check("ovf_full_8", W'(bus.IN_FULL), W'(1));
    end
    check("ovf_drops", W'(bus.DROP_CNT), W'(2));
    ctl_auto = 1'b1;
    wait_pulses(base + 8, 200, "ovf_drain");
    repeat (30) tick();
    check("ovf_exact8", W'(pulse_cnt), W'(base + 8));
    for (int i = 0; i < 8; i++) check("ovf_val", out_log[base + i], vals[i]);
    check("ovf_empty", W'(bus.EMPTY), W'(1));

    // Push into a full queue in the same cycle as a pop
    ctl_auto  = 1'b0;
    ctl_force = 1'b0;
    tick();
    base = pulse_cnt;
    for (int i = 0; i < 8; i++) begin
      vals[i] = $urandom;
      push(vals[i]);
    end
    check("pp_full", W'(bus.IN_FULL), W'(1));
    ctl_force   = 1'b1;
    bus.IN_WE   = 1'b1;
    bus.IN_DATA = 32'hFF;
    tick();
    bus.IN_WE = 1'b0;
    ctl_auto  = 1'b1;
    check("pp_drops", W'(bus.DROP_CNT), W'(2));
    check("pp_still_full", W'(bus.IN_FULL), W'(1));
    wait_pulses(base + 9, 300, "pp_drain");
    for (int i = 0; i < 8; i++) check("pp_val", out_log[base + i], vals[i]);
    check("pp_ninth", out_log[base + 8], 32'hFF);
    repeat (30) tick();

    // Drop-counter saturation
    ctl_auto  = 1'b0;
    ctl_force = 1'b0;
    tick();
    for (int i = 0; i < 8 + 250; i++) push($urandom);
    check("sat_252", W'(bus.DROP_CNT), W'(252));
    for (int i = 0; i < 50; i++) push($urandom);
    check("sat_255", W'(bus.DROP_CNT), W'(255));

    // Reset during a busy transfer
    ctl_hold_min = 20;
    ctl_hold_max = 20;
    ctl_auto = 1'b1;
    base = pulse_cnt;
    wait_pulses(base + 1, 50, "busy_first");
    repeat (3) tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("rb_drop",  W'(bus.DROP_CNT), W'(0));
    check("rb_empty", W'(bus.EMPTY),    W'(1));
    check("rb_we",    W'(bus.OUT_WE),   W'(0));
    check("rb_full",  W'(bus.IN_FULL),  W'(0));
    base = pulse_cnt;
    repeat (100) tick();
    check("rb_no_pulse", W'(pulse_cnt), W'(base));

    // Random traffic with a randomly paced controller
    ctl_hold_min = 1;
    ctl_hold_max = 6;
    for (int i = 0; i < 1500; i++) begin
      bus.IN_WE   = ($urandom_range(0, 99) < ((i < 750) ? 30 : 80));
      bus.IN_DATA = $urandom;
      tick();
    end
    bus.IN_WE = 1'b0;
    for (int n = 0; (n < 2000) && (ref_q.size() > 0); n++) tick();
    repeat (10) tick();
    check("rand_drained", W'(bus.EMPTY), W'(1));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
